dio24_timing: RTL

Timed output stage downstream of the clock-crossing sample FIFO, in the output clock domain. It consumes the FIFO's AXI-stream samples, each a `{time, data}` pair, and runs a board timer. When the timer equals a sample's time it presents that sample's data on the output with a one-cycle strobe. It ends the run after a programmed number of samples and flags late samples.

---
 rtl/dio24_timing_pkg.sv | 12 +
 rtl/dio24_timing_hold.sv | 40 ++++
 rtl/dio24_timing.sv | 108 ++++++++++
 3 files changed

// File: rtl/dio24_timing_pkg.sv
// dio24_timing_pkg: state encoding, default widths and sample field layout
// shared by the dio24 timed output stage.
package dio24_timing_pkg;
    typedef enum logic [1:0] {IDLE, RUN, END, ERROR} state_t;
    localparam int DEF_TIME_BITS = 32;
    localparam int DEF_DATA_BITS = 32;
    localparam int DEF_STREAM_DATA_WIDTH = DEF_TIME_BITS + DEF_DATA_BITS;
    localparam int TIME_LSB = 0;
    function automatic int data_lsb(input int time_bits);
        return TIME_LSB + time_bits;
    endfunction
endpackage

// File: rtl/dio24_timing_hold.sv
// dio24_timing_hold: one-entry sample holding register between the FIFO
// stream and the timed output; refills in the same cycle it is consumed.
module dio24_timing_hold
    import dio24_timing_pkg::*;
#(
    parameter int STREAM_DATA_WIDTH = DEF_STREAM_DATA_WIDTH,
    parameter int TIME_BITS = DEF_TIME_BITS,
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         accept_en,
    input  logic                         consume,
    input  logic [STREAM_DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         hold_valid,
    output logic [TIME_BITS-1:0]         hold_time,
    output logic [DATA_BITS-1:0]         hold_data
);
    logic load;
    assign in_ready = accept_en & (~hold_valid | consume);
    assign load = in_valid & in_ready;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid <= 1'b0;
            hold_time <= '0;
            hold_data <= '0;
        end else if (clear) begin
            hold_valid <= 1'b0;
        end else if (load) begin
            hold_valid <= 1'b1;
            hold_time <= in_data[TIME_LSB +: TIME_BITS];
            hold_data <= in_data[data_lsb(TIME_BITS) +: DATA_BITS];
        end else if (consume) begin
            hold_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/dio24_timing.sv
// dio24_timing: board timer that releases held samples when their time matches.
// Define DIO24_TIMING_LATE_CHECK_EN to trap late samples into ERROR instead of firing them.
module dio24_timing
    import dio24_timing_pkg::*;
#(
    parameter int STREAM_DATA_WIDTH = DEF_STREAM_DATA_WIDTH,
    parameter int TIME_BITS = DEF_TIME_BITS,
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         run,
    input  logic [31:0]                  num_samples,
    input  logic [STREAM_DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [DATA_BITS-1:0]         out_data,
    output logic                         out_strobe,
    output logic [TIME_BITS-1:0]         board_time,
    output logic                         status_run,
    output logic                         status_end,
    output logic                         status_err
);
    state_t state, state_next;
    logic armed;
    logic [31:0] count, num_latch;
    logic hold_valid;
    logic [TIME_BITS-1:0] hold_time;
    logic [DATA_BITS-1:0] hold_data;
    logic in_run, leaving, fire, late, last;

    assign in_run = state == RUN;
    assign leaving = (state != IDLE) && !run;
    assign last = count + 32'd1 == num_latch;
    assign status_run = in_run;
    assign status_end = state == END;

`ifdef DIO24_TIMING_LATE_CHECK_EN
    assign late = in_run & run & hold_valid & (hold_time < board_time);
    assign fire = in_run & run & hold_valid & (hold_time == board_time);
    assign status_err = state == ERROR;
`else
    // Without the check a late sample simply goes out at once and is counted.
    assign late = 1'b0;
    assign fire = in_run & run & hold_valid & (hold_time <= board_time);
    assign status_err = 1'b0;
`endif

    always_comb begin
        state_next = state;
        if (leaving)
            state_next = IDLE;
        else if (state == IDLE && run && num_samples != 32'd0)
            state_next = RUN;
        else if (late)
            state_next = ERROR;
        else if (fire && last)
            state_next = END;
    end

    // armed keeps in_ready low until the first edge after reset release
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            armed <= 1'b0;
            board_time <= '0;
            count <= '0;
            num_latch <= '0;
            out_data <= '0;
            out_strobe <= 1'b0;
        end else begin
            state <= state_next;
            armed <= 1'b1;
            out_strobe <= fire;
            if (fire)
                out_data <= hold_data;
            if (state == IDLE && state_next == RUN)
                num_latch <= num_samples;
            if (state_next == IDLE) begin
                board_time <= '0;
                count <= '0;
            end else begin
                if (in_run)
                    board_time <= board_time + TIME_BITS'(1);
                if (fire)
                    count <= count + 32'd1;
            end
        end
    end

    dio24_timing_hold #(
        .STREAM_DATA_WIDTH(STREAM_DATA_WIDTH),
        .TIME_BITS(TIME_BITS),
        .DATA_BITS(DATA_BITS)
    ) u_hold (
        .clock(clock),
        .reset_n(reset_n),
        .clear(leaving),
        .accept_en(armed & (state == IDLE || in_run) & ~leaving),
        .consume(fire),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .hold_valid(hold_valid),
        .hold_time(hold_time),
        .hold_data(hold_data)
    );
endmodule
